// File: rtl/output_frame_scheduler.sv
// rtl/output_frame_scheduler.sv - sequences encoder tokens into output FIFO body/header writes
// Purpose: accepts literal and copy tokens, emits body bytes (copy = 2 bytes),
//          collects one flag bit per item and writes a FRAME_SIZE-bit header per
//          frame with a minimum header-strobe spacing, then flushes on end-of-stream.
// Ports:   ClkxCI/RstxRBI             clock, async active-low reset
//          TokValidxSI/TokReadyxSO    token handshake; TokIsCopyxSI, TokLitxDI,
//                                     TokOffsetxDI, TokLenxDI token payload
//          EndOfDataxSI               end-of-stream pulse
//          FifoAlmostFullxSI          FIFO backpressure, BuffersEmptyxSI FIFO drained
//          BodyDataxDO/BodyStrobexSO  body byte write port (registered)
//          HeaderDataxDO/HeaderStrobexSO header write port (registered)
//          DonexSO                    stream flushed and drained (registered)
// Option:  `define OFS_STATS_EN adds ItemTotalxDO and StallCyclesxDO counters.
module output_frame_scheduler #(
    parameter int FRAME_SIZE  = 8,
    parameter int MIN_HDR_GAP = 16
) (
    input  logic                  ClkxCI,
    input  logic                  RstxRBI,
    input  logic                  TokValidxSI,
    output logic                  TokReadyxSO,
    input  logic                  TokIsCopyxSI,
    input  logic [7:0]            TokLitxDI,
    input  logic [11:0]           TokOffsetxDI,
    input  logic [3:0]            TokLenxDI,
    input  logic                  EndOfDataxSI,
    input  logic                  FifoAlmostFullxSI,
    input  logic                  BuffersEmptyxSI,
    output logic [7:0]            BodyDataxDO,
    output logic                  BodyStrobexSO,
    output logic [FRAME_SIZE-1:0] HeaderDataxDO,
    output logic                  HeaderStrobexSO,
`ifdef OFS_STATS_EN
    output logic [31:0]           ItemTotalxDO,
    output logic [31:0]           StallCyclesxDO,
`endif
    output logic                  DonexSO
);
    localparam int CNT_W = $clog2(FRAME_SIZE + 1);
    localparam int GAP_W = $clog2(MIN_HDR_GAP + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_SIZE);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(MIN_HDR_GAP - 1);

    typedef enum logic [2:0] {S_RUN, S_COPY2, S_HDR, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_item_cnt;
    logic [FRAME_SIZE-1:0] r_flag_reg;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic                  r_end_pending;
    logic                  r_out_en;
    logic [7:0]            r_copy_lo;
    logic [7:0]            r_body_data;
    logic                  r_body_strobe;
    logic [FRAME_SIZE-1:0] r_hdr_data;
    logic                  r_hdr_strobe;
    logic                  r_done;

    logic                  w_tok_ready;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [FRAME_SIZE-1:0] w_item_bit;

    // r_out_en keeps TokReady low while reset is asserted and for the first cycle after
    assign w_tok_ready = r_out_en & (r_state == S_RUN) & ~r_end_pending & ~FifoAlmostFullxSI;
    assign w_accept    = TokValidxSI & w_tok_ready;
    assign w_cnt_inc   = r_item_cnt + CNT_W'(1);
    assign w_item_bit  = FRAME_SIZE'(1) << r_item_cnt;

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            r_state       <= S_RUN;
            r_item_cnt    <= '0;
            r_flag_reg    <= '0;
            r_gap_cnt     <= '0;
            r_end_pending <= 1'b0;
            r_out_en      <= 1'b0;
            r_copy_lo     <= '0;
            r_body_data   <= '0;
            r_body_strobe <= 1'b0;
            r_hdr_data    <= '0;
            r_hdr_strobe  <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_out_en      <= 1'b1;
            r_body_strobe <= 1'b0;
            r_hdr_strobe  <= 1'b0;
            if (EndOfDataxSI) begin
                r_end_pending <= 1'b1;
            end
            if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_body_strobe <= 1'b1;
                        r_item_cnt    <= w_cnt_inc;
                        if (TokIsCopyxSI) begin
                            r_body_data <= {TokOffsetxDI[11:8], TokLenxDI};
                            r_copy_lo   <= TokOffsetxDI[7:0];
                            r_flag_reg  <= r_flag_reg | w_item_bit;
                            r_state     <= S_COPY2;
                        end else begin
                            r_body_data <= TokLitxDI;
                            if (w_cnt_inc == FRAME_CNT) begin
                                r_state <= S_HDR;
                            end
                        end
                    end else if (r_end_pending) begin
                        // flush: partial header if anything is buffered, else straight to drain
                        r_state <= (r_item_cnt != '0) ? S_HDR : S_DRAIN;
                    end
                end
                S_COPY2: begin
                    // FIFO almost-full margin guarantees room for this second byte
                    r_body_data   <= r_copy_lo;
                    r_body_strobe <= 1'b1;
                    r_state       <= (r_item_cnt == FRAME_CNT) ? S_HDR : S_RUN;
                end
                S_HDR: begin
                    if (r_gap_cnt == '0) begin
                        r_hdr_data   <= r_flag_reg;
                        r_hdr_strobe <= 1'b1;
                        r_flag_reg   <= '0;
                        r_item_cnt   <= '0;
                        r_gap_cnt    <= GAP_LOAD;
                        r_state      <= r_end_pending ? S_DRAIN : S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (BuffersEmptyxSI) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign TokReadyxSO     = w_tok_ready;
    assign BodyDataxDO     = r_body_data;
    assign BodyStrobexSO   = r_body_strobe;
    assign HeaderDataxDO   = r_hdr_data;
    assign HeaderStrobexSO = r_hdr_strobe;
    assign DonexSO         = r_done;

`ifdef OFS_STATS_EN
    logic [31:0] r_item_total;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            r_item_total   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_accept && (r_item_total != '1)) begin
                r_item_total <= r_item_total + 32'd1;
            end
            if (TokValidxSI && !w_tok_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign ItemTotalxDO   = r_item_total;
    assign StallCyclesxDO = r_stall_cycles;
`endif
endmodule

// File: doc/output_frame_scheduler.md
Name: output_frame_scheduler

Overview:
- Sequences encoder output tokens (literals and offset/length copy items) into the output FIFO's body and header write ports.
- Serialises copy items into 2 body bytes.
- Accumulates one flag bit per item and writes one FRAME_SIZE-bit header per completed frame.
- Enforces the FIFO's minimum header-strobe spacing, applies FIFO backpressure to the encoder, and runs end-of-stream flush and done signalling.

Parameters:
FRAME_SIZE, 8, items per frame and header width.
MIN_HDR_GAP, 16, minimum cycles between two HeaderStrobexSO assertions.

Ports:
ClkxCI  in  1  clock
RstxRBI  in  1  reset; one clock; reset is asynchronous and active-low
TokValidxSI  in  1  encoder token valid
TokReadyxSO  out  1  token accepted when Valid & Ready
TokIsCopyxSI  in  1  1 = copy item, 0 = literal
TokLitxDI  in  8  literal byte
TokOffsetxDI  in  12  copy offset
TokLenxDI  in  4  encoded copy length
EndOfDataxSI  in  1  single-cycle end-of-stream pulse
FifoAlmostFullxSI  in  1  FIFO has room for ≤2 more body bytes
BuffersEmptyxSI  in  1  FIFO drained
BodyDataxDO  out  8  body byte to FIFO
BodyStrobexSO  out  1  body write strobe
HeaderDataxDO  out  FRAME_SIZE  header flags to FIFO
HeaderStrobexSO  out  1  header write strobe
DonexSO  out  1  stream fully flushed and drained

Behaviour:
- Reset values: all outputs 0; state RUN; ItemCnt=0; FlagReg=0; GapCnt=0; EndPending=0.
- All FIFO-side outputs are registered.
- States:
  - RUN
  - COPY2
  - HDR
  - DRAIN
  - DONE
- RUN:
  - TokReadyxSO = ~FifoAlmostFullxSI.
  - On accept of a literal: next cycle BodyDataxDO=TokLitxDI, BodyStrobexSO=1; FlagReg[ItemCnt]=0; ItemCnt+1.
  - On accept of a copy: next cycle BodyDataxDO={TokOffsetxDI[11:8],TokLenxDI}, strobe=1; FlagReg[ItemCnt]=1; ItemCnt+1; go COPY2. The second byte (Offset[7:0]) is held in a register.
  - If ItemCnt reaches FRAME_SIZE and the item is a literal, go HDR.
- COPY2:
  - TokReadyxSO=0.
  - Emits the held offset byte with strobe=1 regardless of FifoAlmostFull; FIFO margin covers it.
  - Then go HDR if ItemCnt==FRAME_SIZE, else RUN.
- HDR:
  - TokReadyxSO=0.
  - When GapCnt==0: next cycle HeaderDataxDO=FlagReg and HeaderStrobexSO=1.
  - In that same transition: FlagReg←0, ItemCnt←0, GapCnt←MIN_HDR_GAP-1.
  - Then go DRAIN if EndPending, else RUN.
  - If GapCnt≠0, wait in HDR.
- GapCnt:
  - Decrements by 1 each cycle while nonzero, in every state.
  - Consecutive header strobes are therefore ≥MIN_HDR_GAP cycles apart, rising edge to rising edge.
- Latency:
  - Literal accept at cycle n → body strobe at n+1.
  - Copy accept at n → strobes at n+1 and n+2.
  - Frame-completing item → header strobe at earliest n+2 (literal) or n+3 (copy).
- EndOfDataxSI:
  - Sampled in any state; sets EndPending.
  - A token accepted in the same cycle is processed first. TokReadyxSO stays 0 from the cycle after EndPending is set.
  - On return to RUN with EndPending: if ItemCnt>0, go HDR and emit a partial header, unused upper bits 0; if ItemCnt==0, go DRAIN directly.
- DRAIN:
  - When BuffersEmptyxSI=1, go DONE.
- DONE:
  - DonexSO=1, TokReadyxSO=0.
  - Holds until reset; further EndOfDataxSI pulses and tokens are ignored.
- Simultaneous events:
  - Frame completion and EndOfData in the same cycle produce one full header, then DRAIN; no empty extra header.
- Reset mid-operation clears all state immediately. Partially assembled frames are discarded without emitting a header.
- ItemCnt width is $clog2(FRAME_SIZE+1).
- Header bit i corresponds to the i-th item of the frame, item 0 = bit 0.

Optional Feature:
- Macro: OFS_STATS_EN.
- Defined:
  - Adds output ItemTotalxDO[31:0], counting accepted tokens.
  - Adds output StallCyclesxDO[31:0], counting cycles with TokValidxSI=1 & TokReadyxSO=0.
  - Both reset to 0 and saturate at 2^32-1.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- 8 literals 0x41..0x48 back-to-back, FIFO not full → 8 body strobes with 0x41..0x48 on consecutive cycles; one header 0x00, 2 cycles after the last accept; TokReady low in the header cycle.
- Copy Offset=0xABC, Len=0x5, then 7 literals → body bytes 0xA5, 0xBC, then the literals; header 0x01.
- 16 literals back-to-back → two headers exactly 16 cycles apart; TokReady held low in HDR until GapCnt expires; no lost or duplicated bytes.
- 3 literals + EndOfData pulse, BuffersEmpty raised 5 cycles later → partial header 0x00 with ItemCnt 3; DonexSO rises the cycle after BuffersEmpty is seen; later tokens ignored.
- FifoAlmostFull asserted for 10 cycles mid-frame while TokValid=1 → TokReady=0 for those cycles; an in-flight COPY2 byte still emitted; with OFS_STATS_EN, StallCyclesxDO=10.
- Assert reset mid-frame after 4 items → outputs 0 immediately; next 8 literals form a fresh frame with header strobe at its normal time (GapCnt=0 after reset).
